stream_fifo_sync: RTL
=====================

Name: stream_fifo_sync

Overview:
Parametrised successor to the team's single-stage data/valid block. Adds a DEPTH-entry synchronous FIFO with valid/ready backpressure on both sides, a fill level, an almost-full flag and a sticky overflow flag. Sits between a streaming producer and a consumer that may stall, such as a sensor front-end feeding a processing core.

Parameters:
DATA_WIDTH, 12, width of each data word
ADDR_WIDTH, 4, log2 of depth; DEPTH = 2**ADDR_WIDTH (16)
ALMOST_FULL_THRESH, 12, level at or above which almost_full is asserted; legal range 1..DEPTH

Ports:
clock  input  1  single clock; all logic on the rising edge
reset  input  1  synchronous, active-high reset
data_in  input  DATA_WIDTH  write data from upstream
datavalid_in  input  1  upstream presents a valid word
ready_out  output  1  FIFO can accept a word this cycle
data_out  output  DATA_WIDTH  head-of-FIFO word
datavalid_out  output  1  data_out holds a valid word
ready_in  input  1  downstream accepts the word this cycle
level  output  ADDR_WIDTH+1  current number of stored words, 0..DEPTH
almost_full  output  1  level >= ALMOST_FULL_THRESH
overflow  output  1  sticky; a write was attempted while full
drop_count  output  16  dropped-write counter (see Optional Feature)

Behaviour:
- Reset (reset=1 at a clock edge): write pointer, read pointer and level go to 0; overflow=0; drop_count=0. Memory contents are not cleared.
- Outputs after reset: datavalid_out=0, data_out=0, ready_out=1, level=0, almost_full=0.
- Reset takes priority over any concurrent write or read in the same cycle.
- Write: occurs when datavalid_in && ready_out at a rising edge. mem[wr_ptr]<=data_in, and wr_ptr increments modulo DEPTH (natural ADDR_WIDTH wrap).
- Read: occurs when datavalid_out && ready_in at a rising edge. rd_ptr increments modulo DEPTH.
- Output is first-word-fall-through. datavalid_out = (level != 0). data_out = mem[rd_ptr] when datavalid_out is 1, else all zeros (combinational).
- Latency: a word written into an empty FIFO at edge N has datavalid_out=1 in the cycle after edge N (1 cycle).
- ready_out = (level != DEPTH), combinational from level only. It does not depend on ready_in.
- Full: a write is refused even if a read occurs in the same cycle. There is no pass-through when full.
- Empty: no read is possible, because datavalid_out=0.
- Level update per edge: write only → +1; read only → -1; both → unchanged; neither → unchanged.
- almost_full is combinational from level.
- Overflow: datavalid_in=1 while ready_out=0 drops the word; data and pointers are unchanged. overflow sets to 1 and stays set until reset.
- Ordering: strict FIFO order is preserved, including across pointer wrap-around.
- Unconnected upstream: datavalid_in held at 0 means no writes and no side effects.

Optional Feature:
Macro: STREAM_FIFO_DROP_CNT_EN
- Defined: drop_count is a 16-bit counter that increments on every dropped write (datavalid_in && !ready_out). It saturates at 0xFFFF and is cleared only by reset.
- Not defined: no counter logic is built and drop_count is tied to 0. The overflow flag is unaffected either way.

Test Plan:
- Reset check: assert reset for 2 cycles with datavalid_in=1 → ready_out=1, datavalid_out=0, data_out=0, level=0, overflow=0, no word stored.
- Fill: ready_in=0, write 0x001..0x010 over 16 cycles → almost_full rises the cycle after the 12th write; ready_out=0 and level=16 after the 16th write.
- Overflow: with the FIFO full, drive datavalid_in=1, data_in=0xABC for 3 cycles → overflow=1, level stays 16; drop_count=3 with the macro, 0 without; 0xABC never appears on data_out.
- Drain and order: from full, set ready_in=1 → data_out reads 0x001..0x010 on consecutive cycles; datavalid_out falls after the 16th read; level=0.
- Simultaneous read/write plus wrap: at level 5, write and read every cycle for 20 cycles → level stays 5, output sequence stays in order across pointer wrap, and first-word latency holds.
- Mid-operation reset: at level 9, pulse reset for 1 cycle while writing and reading → next cycle level=0, datavalid_out=0, overflow=0; the following write appears on data_out 1 cycle later.

Source files
------------

// File: rtl/stream_fifo_sync_if.sv
// Streaming handshake bundle for stream_fifo_sync.
// Upstream: data_in / datavalid_in into the FIFO, ready_out back to the producer.
// Downstream: data_out / datavalid_out to the consumer, ready_in back into the FIFO.
// The FIFO uses the slave modport. A producer/consumer pair (or a bench) uses the master modport.
interface stream_fifo_sync_if #(
  parameter int DATA_WIDTH = 12
);
  logic [DATA_WIDTH-1:0] data_in;
  logic                  datavalid_in;
  logic                  ready_out;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  datavalid_out;
  logic                  ready_in;

  // FIFO side: consumes upstream words and the downstream ready, drives the rest.
  modport slave (
    input  data_in,
    input  datavalid_in,
    output ready_out,
    output data_out,
    output datavalid_out,
    input  ready_in
  );

  // Environment side: drives upstream words and the downstream ready.
  modport master (
    output data_in,
    output datavalid_in,
    input  ready_out,
    input  data_out,
    input  datavalid_out,
    output ready_in
  );
endinterface : stream_fifo_sync_if

// File: rtl/stream_fifo_sync.sv
// stream_fifo_sync: DEPTH-entry synchronous first-word-fall-through FIFO.
// Valid/ready backpressure is applied on both sides. The block also reports the
// fill level, an almost-full flag and a sticky overflow flag.
// A write that arrives while the FIFO is full is dropped and sets overflow.
// A read in the same cycle does not make room for that write.
// Optional feature: define STREAM_FIFO_DROP_CNT_EN to build a saturating 16-bit
// dropped-write counter. Without it, drop_count is tied to zero.
module stream_fifo_sync #(
  parameter int DATA_WIDTH         = 12,
  parameter int ADDR_WIDTH         = 4,
  parameter int ALMOST_FULL_THRESH = 12
) (
  input  logic                  clock,
  input  logic                  reset,
  stream_fifo_sync_if.slave     bus,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  almost_full,
  output logic                  overflow,
  output logic [15:0]           drop_count
);

  localparam int                DEPTH      = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] LEVEL_FULL = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] LEVEL_AF   = (ADDR_WIDTH + 1)'(ALMOST_FULL_THRESH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   level_q;

  logic not_full;
  logic not_empty;
  logic wr_en;
  logic rd_en;
  logic drop_en;

  // Handshake decode: accept, deliver and drop decisions for this cycle.
  // NOTE: every signal is assigned on every path through this block, so no latch is inferred.
  always_comb begin
    not_full  = (level_q != LEVEL_FULL);
    not_empty = (level_q != '0);
    wr_en     = bus.datavalid_in && not_full;
    rd_en     = not_empty && bus.ready_in;
    drop_en   = bus.datavalid_in && !not_full;
  end

  assign bus.ready_out     = not_full;
  assign bus.datavalid_out = not_empty;
  assign bus.data_out      = not_empty ? mem[rd_ptr] : '0;
  assign level             = level_q;
  assign almost_full       = (level_q >= LEVEL_AF);

  // Storage array: captures an accepted word at the write pointer.
  // NOTE: the memory has no reset. Clearing the pointers and level is enough to discard its contents.
  always_ff @(posedge clock) begin
    if (!reset && wr_en) begin
      mem[wr_ptr] <= bus.data_in;
    end
  end

  // Pointer registers: natural ADDR_WIDTH wrap gives modulo-DEPTH addressing.
  // NOTE: state is updated with non-blocking assignments, so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Fill level: a simultaneous write and read leaves the level unchanged.
  always_ff @(posedge clock) begin
    if (reset) begin
      level_q <= '0;
    end else begin
      case ({wr_en, rd_en})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  // Sticky overflow: set by any dropped write, cleared only by reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (drop_en) begin
      overflow <= 1'b1;
    end
  end

`ifdef STREAM_FIFO_DROP_CNT_EN
  logic [15:0] drop_cnt_q;

  // Dropped-write counter: saturates at all-ones instead of wrapping.
  always_ff @(posedge clock) begin
    if (reset) begin
      drop_cnt_q <= '0;
    end else if (drop_en && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign drop_count = drop_cnt_q;
`else
  assign drop_count = '0;
`endif

endmodule : stream_fifo_sync
